imem_boot_loader: RTL and testbench

//   Upstream of the single-cycle core: streams a program image from a byte link into instruction memory.

---
 rtl/boot_pkg.sv | 6 +
 rtl/word_assembler.sv | 25 ++
 rtl/imem_boot_loader.sv | 111 +++++++++++
 tb/tb_imem_boot_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// boot_pkg: shared state encoding and framing constants for the instruction-memory boot loader.
package boot_pkg;
  typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, CSUM, DRAIN, DONE, ERR} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES = 2;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs a big-endian byte stream into 32-bit words; word_valid marks the completing byte.
module word_assembler
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  din,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [23:0] sh;
  logic [1:0] idx;
  assign word_valid = en && idx == 2'(BYTES_PER_WORD - 1);
  assign word = {sh, din};
  always_ff @(posedge clk) begin
    if (rst) begin
      sh <= '0;
      idx <= '0;
    end else if (en) begin
      sh <= {sh[15:0], din};
      idx <= idx + 2'd1;
    end
  end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a framed byte image into instruction memory, holding the core in reset until done.
// Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [7:0]            In_Data,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  output logic                  Imem_We,
  output logic [ADDR_WIDTH-1:0] Imem_Addr,
  output logic [DATA_WIDTH-1:0] Imem_Wdata,
  output logic                  Cpu_Rst,
  output logic                  Load_Done,
  output logic                  Load_Err,
  output logic [15:0]           Words_Loaded
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef BOOT_CHECKSUM_EN
  localparam state_t END_ST = CSUM;
  logic [7:0] csum;
`else
  localparam state_t END_ST = DRAIN;
`endif
  state_t state;
  logic [7:0] n_hi;
  logic [15:0] n;
  logic acc, wv, last;
  logic [31:0] word;
  logic [16:0] n_rx;
  assign acc = In_Valid & In_Ready;
  assign n_rx = {1'b0, n_hi, In_Data};
  // Words_Loaded already counts every earlier word when a word's final byte arrives
  assign last = wv && (Words_Loaded + 16'd1 == n);
  word_assembler u_asm (
    .clk(Clk),
    .rst(Rst),
    .en(acc && state == DATA),
    .din(In_Data),
    .word_valid(wv),
    .word(word)
  );
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= HDR_HI;
      In_Ready <= 1'b1;
      Imem_We <= 1'b0;
      Imem_Addr <= '0;
      Imem_Wdata <= '0;
      Cpu_Rst <= 1'b1;
      Load_Done <= 1'b0;
      Load_Err <= 1'b0;
      Words_Loaded <= '0;
      n_hi <= '0;
      n <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      Imem_We <= wv;
      if (wv) begin
        Imem_Addr <= Words_Loaded[ADDR_WIDTH-1:0];
        Imem_Wdata <= word;
        Words_Loaded <= Words_Loaded + 16'd1;
      end
      case (state)
        HDR_HI: if (acc) begin
          n_hi <= In_Data;
          state <= HDR_LO;
        end
        HDR_LO: if (acc) begin
          n <= n_rx[15:0];
          if (n_rx > 17'(DEPTH)) begin
            state <= ERR;
            In_Ready <= 1'b0;
            Load_Err <= 1'b1;
          end else if (n_rx == 17'd0) begin
            state <= END_ST;
            In_Ready <= END_ST == CSUM;
          end else state <= DATA;
        end
        DATA: if (acc) begin
`ifdef BOOT_CHECKSUM_EN
          csum <= csum ^ In_Data;
`endif
          if (last) begin
            state <= END_ST;
            In_Ready <= END_ST == CSUM;
          end
        end
`ifdef BOOT_CHECKSUM_EN
        CSUM: if (acc) begin
          In_Ready <= 1'b0;
          state <= In_Data == csum ? DRAIN : ERR;
          Load_Err <= In_Data != csum;
        end
`endif
        DRAIN: begin
          state <= DONE;
          Load_Done <= 1'b1;
          Cpu_Rst <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: frame-level model of accepted bytes checked every cycle, plus literal write/timing pins.
module tb_imem_boot_loader;
  localparam int AW = 8;
  localparam int DEPTH = 2 ** AW;
`ifdef BOOT_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  logic Clk = 0, Rst = 1, In_Valid = 0;
  logic [7:0] In_Data = 0;
  logic In_Ready, Imem_We, Cpu_Rst, Load_Done, Load_Err;
  logic [AW-1:0] Imem_Addr;
  logic [31:0] Imem_Wdata;
  logic [15:0] Words_Loaded;
  int n_chk = 0, n_fail = 0;
  bit go = 0;
  logic [7:0] rx[$];
  int post = 0;
  bit m_we = 0;
  logic [39:0] wlog[$];

  always #5 Clk = ~Clk;

  imem_boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Imem_We(Imem_We), .Imem_Addr(Imem_Addr), .Imem_Wdata(Imem_Wdata), .Cpu_Rst(Cpu_Rst),
    .Load_Done(Load_Done), .Load_Err(Load_Err), .Words_Loaded(Words_Loaded)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: everything derives from the list of bytes the loader has accepted
  function automatic int m_n();
    return rx.size() >= 2 ? int'({rx[0], rx[1]}) : 0;
  endfunction
  function automatic bit m_bad();
    return rx.size() >= 2 && m_n() > DEPTH;
  endfunction
  function automatic bit m_complete();
    return rx.size() >= 2 && !m_bad() && rx.size() == 2 + 4 * m_n() + CS;
  endfunction
  function automatic bit m_csbad();
    logic [7:0] x = 0;
    if (CS == 0 || !m_complete()) return 0;
    for (int i = 2; i < rx.size() - 1; i++) x ^= rx[i];
    return x != rx[rx.size()-1];
  endfunction
  function automatic bit m_ready();
    return !m_bad() && !m_csbad() && !m_complete();
  endfunction
  function automatic int m_words();
    int w;
    if (rx.size() < 2) return 0;
    w = (rx.size() - 2) / 4;
    return w < m_n() ? w : m_n();
  endfunction
  function automatic logic [31:0] m_word(input int k);
    return {rx[2+4*k], rx[3+4*k], rx[4+4*k], rx[5+4*k]};
  endfunction

  always @(posedge Clk) begin
    if (Rst) begin
      rx.delete();
      post = 0;
      m_we = 0;
    end else begin
      if (m_complete()) post++;
      m_we = 0;
      if (In_Valid && m_ready()) begin
        rx.push_back(In_Data);
        if (rx.size() > 2 && (rx.size() - 2) % 4 == 0 && (rx.size() - 2) / 4 <= m_n()) m_we = 1;
      end
    end
  end

  always @(negedge Clk) begin
    if (go) begin
      bit done;
      done = m_complete() && !m_csbad() && post >= 1;
      chk("in_ready", In_Ready, m_ready());
      chk("load_err", Load_Err, m_bad() || m_csbad());
      chk("load_done", Load_Done, done);
      chk("cpu_rst", Cpu_Rst, !done);
      chk("words_loaded", Words_Loaded, m_words());
      chk("imem_we", Imem_We, m_we);
      if (m_we) begin
        chk("imem_addr", Imem_Addr, m_words() - 1);
        chk("imem_wdata", Imem_Wdata, m_word(m_words() - 1));
      end
      if (Imem_We) wlog.push_back({Imem_Addr, Imem_Wdata});
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    bit rdy;
    In_Valid = 0;
    repeat (gap) @(posedge Clk);
    #1;
    In_Valid = 1;
    In_Data = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge Clk) rdy = In_Ready;
      @(posedge Clk);
      #1;
      if (rdy) begin
        In_Valid = 0;
        return;
      end
    end
    chk("accept_timeout", 0, 1);
    In_Valid = 0;
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit gaps);
    foreach (f[i]) send(f[i], gaps ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic do_reset();
    Rst = 1;
    @(posedge Clk);
    #1;
    Rst = 0;
    wlog.delete();
  endtask

  task automatic check_image();
    chk("wlog_size", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("w0", wlog[0][31:0], 32'h20000001);
      chk("w0_addr", wlog[0][39:32], 0);
      chk("w1", wlog[1][31:0], 32'h30000002);
      chk("w1_addr", wlog[1][39:32], 1);
      chk("w2", wlog[2][31:0], 32'h40000003);
      chk("w2_addr", wlog[2][39:32], 2);
    end
  endtask

  initial begin
    logic [7:0] f[$];
    @(posedge Clk);
    #1;
    go = 1;
    Rst = 0;
    @(negedge Clk);
    chk("rst_in_ready", In_Ready, 1);
    chk("rst_cpu_rst", Cpu_Rst, 1);
    chk("rst_words", Words_Loaded, 0);
    chk("rst_addr", Imem_Addr, 0);
    chk("rst_wdata", Imem_Wdata, 0);
    @(posedge Clk);
    #1;
    // three-word image, back to back; checksum 0x50 is the XOR of the payload
    f = '{8'h00, 8'h03, 8'h20, 8'h00, 8'h00, 8'h01, 8'h30, 8'h00, 8'h00, 8'h02, 8'h40, 8'h00, 8'h00, 8'h03};
    if (CS != 0) f.push_back(8'h50);
    send_frame(f, 0);
    @(negedge Clk);
    chk("drain_cpu_rst", Cpu_Rst, 1);
    chk("drain_in_ready", In_Ready, 0);
    @(negedge Clk);
    chk("done_cpu_rst", Cpu_Rst, 0);
    chk("done_flag", Load_Done, 1);
    chk("done_words", Words_Loaded, 3);
    check_image();
    do_reset();
    send_frame(f, 1);
    repeat (3) @(posedge Clk);
    #1;
    check_image();
    chk("gap_done", Load_Done, 1);
    // empty image
    do_reset();
    f = '{8'h00, 8'h00};
    if (CS != 0) f.push_back(8'h00);
    send_frame(f, 0);
    repeat (2) @(negedge Clk);
    chk("n0_done", Load_Done, 1);
    chk("n0_words", Words_Loaded, 0);
    chk("n0_writes", wlog.size(), 0);
    // oversize word count
    do_reset();
    send_frame('{8'h01, 8'h01}, 0);
    In_Valid = 1;
    In_Data = 8'h55;
    @(negedge Clk);
    chk("big_err", Load_Err, 1);
    chk("big_ready", In_Ready, 0);
    chk("big_cpu_rst", Cpu_Rst, 1);
    repeat (4) @(negedge Clk);
    In_Valid = 0;
    chk("big_writes", wlog.size(), 0);
    chk("big_err_sticky", Load_Err, 1);
`ifdef BOOT_CHECKSUM_EN
    do_reset();
    send_frame('{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44}, 0);
    repeat (2) @(negedge Clk);
    chk("cs_good_done", Load_Done, 1);
    do_reset();
    send_frame('{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45}, 0);
    repeat (2) @(negedge Clk);
    chk("cs_bad_err", Load_Err, 1);
    chk("cs_bad_cpu_rst", Cpu_Rst, 1);
    chk("cs_bad_writes", wlog.size(), 1);
    if (wlog.size() == 1) chk("cs_bad_w0", wlog[0], 40'h00_11223344);
`endif
    // abort mid-word, then a fresh single-word frame
    do_reset();
    send_frame('{8'h00, 8'h01, 8'hAA, 8'hBB}, 0);
    do_reset();
    @(negedge Clk);
    chk("abort_ready", In_Ready, 1);
    chk("abort_cpu_rst", Cpu_Rst, 1);
    chk("abort_words", Words_Loaded, 0);
    @(posedge Clk);
    #1;
    f = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    if (CS != 0) f.push_back(8'h22);
    send_frame(f, 0);
    repeat (2) @(negedge Clk);
    chk("fresh_done", Load_Done, 1);
    chk("fresh_writes", wlog.size(), 1);
    if (wlog.size() == 1) chk("fresh_w0", wlog[0], 40'h00_DEADBEEF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
